// File: rtl/systolic_pe_array_if.sv
// Bus bundle between the systolic controller (master) and the N x N PE array (slave).
interface systolic_pe_array_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic                    clear;
    logic signed [WIDTH-1:0] act_in     [N];
    logic        [N-1:0]     enable;
    logic signed [WIDTH-1:0] weight_in  [N][N];
    logic signed [WIDTH-1:0] result_col [N];
    logic                    result_valid;
    logic                    overflow;

    modport master (
        output clear, act_in, enable, weight_in,
        input  result_col, result_valid, overflow
    );

    modport slave (
        input  clear, act_in, enable, weight_in,
        output result_col, result_valid, overflow
    );
endinterface

// File: rtl/systolic_pe_array.sv
// Weight-stationary N x N systolic MAC array with per-column output deskew and sticky overflow.
// Define SYSTOLIC_SAT_EN to saturate overflowing partial sums; otherwise they wrap.
module systolic_pe_array #(
    parameter int N     = 4,
    parameter int WIDTH = 16
) (
    input logic                clk,
    input logic                rst,
    systolic_pe_array_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int SW = 2 * WIDTH + 1;
    localparam int VD = 2 * N - 1;
    localparam logic signed [SW-1:0] MAXV = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] reduce_sum(input logic signed [SW-1:0] s);
        logic signed [WIDTH-1:0] r;
        r = WIDTH'(s);
`ifdef SYSTOLIC_SAT_EN
        if (s > MAXV) begin
            r = MAXV[WIDTH-1:0];
        end else if (s < MINV) begin
            r = MINV[WIDTH-1:0];
        end
`endif
        return r;
    endfunction

    logic signed [WIDTH-1:0] a_p0  [N][N];
    logic signed [WIDTH-1:0] p_p0  [N][N];
    logic signed [WIDTH-1:0] a_nxt [N][N];
    logic signed [WIDTH-1:0] p_nxt [N][N];
    logic        [N*N-1:0]   ovf_evt;
    logic        [VD-1:0]    vld_p;
    logic                    ovf_q;

    // Stage 0 inputs: activations enter at column 0 and ripple right, partial sums flow down.
    for (genvar k = 0; k < N; k++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [WIDTH-1:0] p_in;
            logic signed [PW-1:0]    prod;
            logic signed [SW-1:0]    sum;

            if (j == 0) begin : g_edge
                assign a_nxt[k][j] = bus.enable[k] ? bus.act_in[k] : '0;
            end else begin : g_chain
                assign a_nxt[k][j] = a_p0[k][j-1];
            end

            if (k == 0) begin : g_top
                assign p_in = '0;
            end else begin : g_down
                assign p_in = p_p0[k-1][j];
            end

            // Weight bus is transposed by the controller, hence [j][k].
            assign prod               = PW'(a_nxt[k][j]) * PW'(bus.weight_in[j][k]);
            assign sum                = SW'(p_in) + SW'(prod);
            assign ovf_evt[k*N+j]     = (sum > MAXV) || (sum < MINV);
            assign p_nxt[k][j]        = reduce_sum(sum);
        end
    end

    // Stage 0 registers: PE a_reg/p_reg, row-marker pipeline and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    a_p0[k][j] <= '0;
                    p_p0[k][j] <= '0;
                end
            end
            vld_p <= '0;
            ovf_q <= 1'b0;
        end else if (bus.clear) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    a_p0[k][j] <= '0;
                    p_p0[k][j] <= '0;
                end
            end
            vld_p <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < N; j++) begin
                    a_p0[k][j] <= a_nxt[k][j];
                    p_p0[k][j] <= p_nxt[k][j];
                end
            end
            vld_p <= {vld_p[VD-2:0], bus.enable[0]};
            ovf_q <= ovf_q | (|ovf_evt);
        end
    end

    // Deskew stage: column j finishes j cycles after column 0, so it waits N-1-j cycles.
    for (genvar j = 0; j < N; j++) begin : g_dsk
        if (j == N - 1) begin : g_direct
            assign bus.result_col[j] = p_p0[N-1][j];
        end else begin : g_delay
            localparam int D = N - 1 - j;
            logic signed [WIDTH-1:0] dsk_p [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < D; s++) dsk_p[s] <= '0;
                end else if (bus.clear) begin
                    for (int s = 0; s < D; s++) dsk_p[s] <= '0;
                end else begin
                    dsk_p[0] <= p_p0[N-1][j];
                    for (int s = 1; s < D; s++) dsk_p[s] <= dsk_p[s-1];
                end
            end

            assign bus.result_col[j] = dsk_p[D-1];
        end
    end

    assign bus.result_valid = vld_p[VD-1];
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_systolic_pe_array.sv
// Directed scoreboard bench for systolic_pe_array (N=4, WIDTH=16).
module tb_systolic_pe_array;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int LAT = 2 * N - 1;

    typedef struct packed {
        logic [31:0]    due;
        logic [N*W-1:0] cols;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   a_m [N][N];
    int   b_m [N][N];

    systolic_pe_array_if #(.N(N), .WIDTH(W)) bus ();
    systolic_pe_array #(.N(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    function automatic longint red(input longint s);
`ifdef SYSTOLIC_SAT_EN
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        logic signed [W-1:0] t;
        t = W'(s);
        return longint'(t);
`endif
    endfunction

    task automatic push_row(input int r, input int due);
        exp_t   e;
        longint acc;
        e.due  = 32'(due);
        e.cols = '0;
        for (int j = 0; j < N; j++) begin
            acc = 0;
            for (int k = 0; k < N; k++) acc = red(acc + longint'(a_m[r][k]) * longint'(b_m[k][j]));
            e.cols[j*W +: W] = W'(acc);
        end
        sb.push_back(e);
    endtask

    task automatic set_weights();
        for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++) bus.weight_in[j][k] = W'(b_m[k][j]);
    endtask

    task automatic idle_inputs();
        bus.clear  = 1'b0;
        bus.enable = '0;
        for (int k = 0; k < N; k++) bus.act_in[k] = '0;
    endtask

    task automatic run_matrix(input int gap, input int stop_t);
        int t_total;
        t_total = (N - 1) * (gap + 1) + N;
        if (stop_t < t_total) t_total = stop_t;
        for (int t = 0; t < t_total; t++) begin
            bus.enable = '0;
            for (int k = 0; k < N; k++) bus.act_in[k] = '0;
            for (int k = 0; k < N; k++) begin
                for (int r = 0; r < N; r++) begin
                    if (t - k == r * (gap + 1)) begin
                        bus.enable[k] = 1'b1;
                        bus.act_in[k] = W'(a_m[r][k]);
                        if (k == 0) push_row(r, cyc + LAT);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_cols_zero(input string tag);
        for (int j = 0; j < N; j++) begin
            checks++;
            assert (bus.result_col[j] === 16'sd0) else begin
                errors++;
                $error("FAIL %s col%0d: observed %0d expected 0", tag, j, bus.result_col[j]);
            end
        end
    endtask

    task automatic drain(input string tag);
        repeat (LAT + 3) @(posedge clk);
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain: observed %0d pending rows expected 0", tag, sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.result_valid === 1'b1) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_valid: observed valid at cycle %0d expected none", cyc);
                end
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    checks++;
                    assert (cyc === int'(mon_e.due)) else begin
                        errors++;
                        $error("FAIL valid_time: observed cycle %0d expected cycle %0d", cyc, mon_e.due);
                    end
                    for (int j = 0; j < N; j++) begin
                        checks++;
                        assert (bus.result_col[j] === mon_e.cols[j*W +: W]) else begin
                            errors++;
                            $error("FAIL result_col%0d: observed %0d expected %0d at cycle %0d",
                                   j, bus.result_col[j], $signed(mon_e.cols[j*W +: W]), cyc);
                        end
                    end
                end
            end else if (sb.size() > 0 && int'(sb[0].due) <= cyc) begin
                mon_e = sb.pop_front();
                checks++;
                assert (bus.result_valid === 1'b1) else begin
                    errors++;
                    $error("FAIL missing_valid: observed 0 expected 1 at cycle %0d", cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) b_m[k][j] = 0;
        set_weights();
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_valid", bus.result_valid, 1'b0);
        check_bit("reset_ovf", bus.overflow, 1'b0);
        check_cols_zero("reset_cols");
        rst = 1'b0;

        // Identity weights: each result row reproduces the activation row.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                a_m[r][k] = 4 * r + k + 1;
                b_m[r][k] = (r == k) ? 1 : 0;
            end
        set_weights();
        run_matrix(0, 100);
        drain("identity");
        check_bit("identity_ovf", bus.overflow, 1'b0);

        // General signed product.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                a_m[r][k] = r + k;
                b_m[r][k] = r - k;
            end
        set_weights();
        run_matrix(0, 100);
        drain("general");

        // Reset while rows are in flight, then restart.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                a_m[r][k] = 4 * r + k + 1;
                b_m[r][k] = (r == k) ? 1 : 0;
            end
        set_weights();
        run_matrix(0, 9);
        check_bit("valid_before_rst", bus.result_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("midrst_valid", bus.result_valid, 1'b0);
        check_bit("midrst_ovf", bus.overflow, 1'b0);
        check_cols_zero("midrst_cols");
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_matrix(0, 100);
        drain("restart");

        // Two idle cycles between rows.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                a_m[r][k] = r + k;
                b_m[r][k] = r - k;
            end
        set_weights();
        run_matrix(2, 100);
        drain("gaps");

        // Overflow on every accumulation.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                a_m[r][k] = 300;
                b_m[r][k] = 300;
            end
        set_weights();
        run_matrix(0, 100);
        check_bit("ovf_set", bus.overflow, 1'b1);
        drain("overflow");
        check_bit("ovf_sticky", bus.overflow, 1'b1);

        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        check_bit("clear_ovf", bus.overflow, 1'b0);
        check_bit("clear_valid", bus.result_valid, 1'b0);

        // Negative operands.
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                a_m[r][k] = -1;
                b_m[r][k] = 2;
            end
        set_weights();
        run_matrix(0, 100);
        drain("negative");
        check_bit("negative_ovf", bus.overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_pe_array.md
SYSTOLIC_PE_ARRAY -- requirements
Module: systolic_pe_array

Interface
REQ-001 Parameter N, default 4: array dimension, N x N PEs.
REQ-002 Parameter WIDTH, default 16: signed operand and result width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush of all pipeline, deskew and overflow state.
REQ-006 act_in[N]  input  WIDTH signed each  skewed activation for PE row k (controller data_up).
REQ-007 enable[N]  input  1 each  act_in[k] valid qualifier.
REQ-008 weight_in[N][N]  input  WIDTH signed each  stationary weights, sampled every cycle.
REQ-009 result_col[N]  output  WIDTH signed each  deskewed result row, column j.
REQ-010 result_valid  output  1  result_col holds a complete result row.
REQ-011 overflow  output  1  sticky accumulation overflow flag.

Function
REQ-012 PE(k,j) SHALL use weight w = weight_in[j][k], so the controller's transposed weight bus yields B[k][j].
REQ-013 PE(k,j) a_in SHALL be act_in[k] gated to 0 when enable[k]=0 for j=0, else a_reg of PE(k,j-1).
REQ-014 PE(k,j) p_in SHALL be 0 for k=0, else p_reg of PE(k-1,j).
REQ-015 Each edge: a_reg <= a_in; p_reg <= p_in + a_in*w; product formed at 2*WIDTH, sum evaluated at 2*WIDTH+1 before reduction to WIDTH.
REQ-016 Input schedule: A[r][k] on act_in[k] with enable[k]=1 in cycle r+k (r = row index, cycle 0 = first A[0][0]).
REQ-017 p_reg of PE(N-1,j) SHALL hold C[r][j] = sum_k A[r][k]*B[k][j] during cycle r+N+j.
REQ-018 Column j SHALL pass through N-1-j deskew registers, so result_col[j] for row r is valid in cycle r+2N-1 for every j.
REQ-019 result_valid SHALL be enable[0] delayed by exactly 2N-1 registers (row-r marker).
REQ-020 Reduction to WIDTH: sum outside signed WIDTH range is an overflow event; value per REQ-031/032.
REQ-021 Any overflow event in any PE SHALL set overflow on the following edge; it stays 1 until clear or rst.
REQ-022 Back-to-back rows with no gap SHALL produce back-to-back result rows, one per cycle, no bubbles.
REQ-023 enable low between rows SHALL inject zero contributions; no state retained from earlier rows except overflow.
REQ-024 Weights SHALL NOT be latched; weight_in must stay stable from first act_in of a matrix until its last result_valid.
REQ-025 clear=1 SHALL zero all a_reg, p_reg, deskew, valid and overflow state next edge; clear has priority over concurrent inputs and overflow events.

Reset
REQ-026 rst SHALL asynchronously zero every a_reg, p_reg, deskew register, valid pipeline and overflow.
REQ-027 During and after reset: result_col[j]=0, result_valid=0, overflow=0.
REQ-028 Reset mid-operation SHALL discard all in-flight rows; no result_valid until 2N-1 cycles after new enable[0]=1.
REQ-029 Release of rst SHALL need no extra cycles; first edge after release behaves per REQ-015.

Configuration
REQ-030 Macro SYSTOLIC_SAT_EN selects overflow reduction.
REQ-031 Defined: overflowing sums SHALL saturate to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
REQ-032 Undefined: overflowing sums SHALL wrap (two's-complement truncation to WIDTH LSBs); overflow flag behaviour identical.

Verification (N=4, WIDTH=16)
REQ-033 Reset: rst high mid-stream -> all outputs 0 immediately; result_valid stays 0 for 7 cycles after restart.
REQ-034 Identity: B=I, A rows {1,2,3,4}..{13,14,15,16} skewed -> result_col = A row r in cycle r+7, result_valid high cycles 7-10.
REQ-035 General: A[r][k]=r+k, B[k][j]=k-j -> result_col matches reference product each valid cycle, all columns aligned.
REQ-036 Overflow: A all 300, B all 300 -> overflow=1 from first accumulation; result 32767 with SYSTOLIC_SAT_EN, wrapped 360000 mod 2^16 as signed without.
REQ-037 Gaps/clear: enable low 2 cycles between rows -> matching 2-cycle gap in result_valid; clear asserted with overflow=1 -> overflow=0 next cycle.
REQ-038 Negative: A=-1 all, B=2 all -> every result -8, overflow stays 0.
